// File: rtl/ifu_predec_q_pkg.sv
// Shared widths, opcode/RVC constants and the decoded-entry record for the
// IFU pre-decode queue.
package ifu_predec_q_pkg;

  localparam int E203_XLEN_32 = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] RV32_LEN = 2'b11;
  localparam logic [1:0] RVC_Q1   = 2'b01;
  localparam logic [1:0] RVC_Q2   = 2'b10;

  localparam logic [2:0] RVC_F3_JAL  = 3'b001;
  localparam logic [2:0] RVC_F3_JR   = 3'b100;
  localparam logic [2:0] RVC_F3_J    = 3'b101;
  localparam logic [2:0] RVC_F3_BEQZ = 3'b110;
  localparam logic [2:0] RVC_F3_BNEZ = 3'b111;

  typedef struct packed {
    logic       rv32;
    logic       ilgl;
    logic       bjp;
    logic       jal;
    logic       jalr;
    logic       bxx;
    logic       rs1_en;
    logic       rs2_en;
    logic [4:0] rs1idx;
    logic [4:0] rs2idx;
    logic       prdt_taken;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  // Compressed 3-bit register fields address x8..x15.
  function automatic logic [4:0] rvc_creg(input logic [2:0] r);
    return {2'b01, r};
  endfunction

endpackage

// File: rtl/ifu_predec_q_dec.sv
// Combinational branch pre-decoder: classifies one fetch word, extracts the
// branch/jump offset and forms the static BTFN prediction.
module ifu_predec_q_dec
  import ifu_predec_q_pkg::*;
#(
  parameter int XLEN    = E203_XLEN_32,
  parameter int RVC_EN  = 1,
  parameter int BTFN_EN = 1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output dec_t            dec,
  output logic [XLEN-1:0] bjp_imm,
  output logic [XLEN-1:0] prdt_pc
);

  logic               rv32;
  logic signed [20:0] j_imm;
  logic signed [12:0] b_imm;
  logic signed [11:0] i_imm;
  logic signed [11:0] cj_imm;
  logic signed [8:0]  cb_imm;
  logic signed [XLEN-1:0] imm_sx;

  assign rv32   = (instr[1:0] == RV32_LEN);
  assign j_imm  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign b_imm  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign i_imm  = instr[31:20];
  assign cj_imm = {instr[12], instr[8], instr[10:9], instr[6], instr[7],
                   instr[2], instr[11], instr[5:3], 1'b0};
  assign cb_imm = {instr[12], instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};

  // Register-use flags describe branch/jump operands only; other instructions
  // report no sources since the consumer only needs them for jump resolution.
  always_comb begin
    dec      = '0;
    imm_sx   = '0;
    dec.rv32 = rv32;
    if (rv32) begin
      case (instr[6:0])
        OPC_JAL: begin
          dec.jal = 1'b1;
          imm_sx  = XLEN'(j_imm);
        end
        OPC_JALR: begin
          dec.jalr   = 1'b1;
          dec.rs1_en = 1'b1;
          dec.rs1idx = instr[19:15];
          imm_sx     = XLEN'(i_imm);
        end
        OPC_BRANCH: begin
          dec.bxx    = 1'b1;
          dec.rs1_en = 1'b1;
          dec.rs2_en = 1'b1;
          dec.rs1idx = instr[19:15];
          dec.rs2idx = instr[24:20];
          imm_sx     = XLEN'(b_imm);
        end
        default: ;
      endcase
    end else if (RVC_EN != 0) begin
      if (instr[1:0] == RVC_Q1) begin
        if ((instr[15:13] == RVC_F3_J) ||
            ((instr[15:13] == RVC_F3_JAL) && (XLEN == E203_XLEN_32))) begin
          dec.jal = 1'b1;
          imm_sx  = XLEN'(cj_imm);
        end else if ((instr[15:13] == RVC_F3_BEQZ) || (instr[15:13] == RVC_F3_BNEZ)) begin
          dec.bxx    = 1'b1;
          dec.rs1_en = 1'b1;
          dec.rs1idx = rvc_creg(instr[9:7]);
          imm_sx     = XLEN'(cb_imm);
        end
      end else if ((instr[1:0] == RVC_Q2) && (instr[15:13] == RVC_F3_JR) &&
                   (instr[11:7] != 5'd0) && (instr[6:2] == 5'd0)) begin
        // c.jr (bit12=0) and c.jalr (bit12=1) share everything but the link.
        dec.jalr   = 1'b1;
        dec.rs1_en = 1'b1;
        dec.rs1idx = instr[11:7];
      end
    end else begin
      dec.ilgl = 1'b1;
    end

    dec.bjp        = dec.jal | dec.jalr | dec.bxx;
    dec.prdt_taken = dec.jal | dec.jalr |
                     (dec.bxx & (BTFN_EN != 0) & imm_sx[XLEN-1]);
  end

  assign bjp_imm = $unsigned(imm_sx);
  assign prdt_pc = (dec.jal | dec.bxx) ? (pc + $unsigned(imm_sx)) : '0;

endmodule

// File: rtl/ifu_predec_q.sv
// IFU instruction queue: pre-decodes each accepted fetch word on enqueue and
// presents entries in order at the head with valid/ready on both sides.
module ifu_predec_q
  import ifu_predec_q_pkg::*;
#(
  parameter int XLEN    = E203_XLEN_32,
  parameter int DEPTH   = 4,
  parameter int RVC_EN  = 1,
  parameter int BTFN_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [31:0]                i_instr,
  input  logic [XLEN-1:0]            i_pc,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [31:0]                o_instr,
  output logic [XLEN-1:0]            o_pc,
  output logic                       o_rv32,
  output logic                       o_ilgl,
  output logic                       o_bjp,
  output logic                       o_jal,
  output logic                       o_jalr,
  output logic                       o_bxx,
  output logic                       o_rs1_en,
  output logic                       o_rs2_en,
  output logic [4:0]                 o_rs1idx,
  output logic [4:0]                 o_rs2idx,
  output logic [XLEN-1:0]            o_bjp_imm,
  output logic                       o_prdt_taken,
  output logic [XLEN-1:0]            o_prdt_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  dec_t            dec_p0;
  logic [XLEN-1:0] bjp_imm_p0;
  logic [XLEN-1:0] prdt_pc_p0;

  ifu_predec_q_dec #(
    .XLEN    (XLEN),
    .RVC_EN  (RVC_EN),
    .BTFN_EN (BTFN_EN)
  ) u_dec (
    .instr   (i_instr),
    .pc      (i_pc),
    .dec     (dec_p0),
    .bjp_imm (bjp_imm_p0),
    .prdt_pc (prdt_pc_p0)
  );

  // ---- p0 -> p1: enqueue into entry storage ----
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             enq, deq, vld_p1;

  logic [31:0]      instr_mem_p1   [DEPTH];
  logic [XLEN-1:0]  pc_mem_p1      [DEPTH];
  logic [XLEN-1:0]  imm_mem_p1     [DEPTH];
  logic [XLEN-1:0]  prdt_pc_mem_p1 [DEPTH];
  logic [DEC_W-1:0] dec_mem_p1     [DEPTH];

  assign wr_idx  = wr_ptr[IDX_W-1:0];
  assign rd_idx  = rd_ptr[IDX_W-1:0];
  assign o_count = CNT_W'(wr_ptr - rd_ptr);
  assign vld_p1  = (wr_ptr != rd_ptr);
  assign i_ready = (o_count != CNT_W'(DEPTH));
  assign enq     = i_valid & i_ready & ~flush;
  assign deq     = vld_p1 & o_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem_p1[wr_idx]   <= i_instr;
      pc_mem_p1[wr_idx]      <= i_pc;
      imm_mem_p1[wr_idx]     <= bjp_imm_p0;
      prdt_pc_mem_p1[wr_idx] <= prdt_pc_p0;
      dec_mem_p1[wr_idx]     <= dec_p0;
    end
  end

  // ---- p1: head entry presented to dispatch ----
  dec_t head_p1;
  assign head_p1 = dec_t'(dec_mem_p1[rd_idx]);

  assign o_valid      = vld_p1;
  assign o_instr      = instr_mem_p1[rd_idx];
  assign o_pc         = pc_mem_p1[rd_idx];
  assign o_bjp_imm    = imm_mem_p1[rd_idx];
  assign o_prdt_pc    = prdt_pc_mem_p1[rd_idx];
  assign o_rv32       = head_p1.rv32;
  assign o_ilgl       = head_p1.ilgl;
  assign o_bjp        = head_p1.bjp;
  assign o_jal        = head_p1.jal;
  assign o_jalr       = head_p1.jalr;
  assign o_bxx        = head_p1.bxx;
  assign o_rs1_en     = head_p1.rs1_en;
  assign o_rs2_en     = head_p1.rs2_en;
  assign o_rs1idx     = head_p1.rs1idx;
  assign o_rs2idx     = head_p1.rs2idx;
  assign o_prdt_taken = head_p1.prdt_taken;

endmodule

// File: tb/tb_ifu_predec_q.sv
// Scoreboard bench for ifu_predec_q: a default instance plus one with RVC and
// BTFN disabled, both driven by the same directed stimulus.
module tb_ifu_predec_q;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, i_valid = 1'b0, o_ready = 1'b0;
  logic [31:0] i_instr = '0;
  logic [XLEN-1:0] i_pc = '0;

  logic m_i_ready, m_o_valid, m_o_rv32, m_o_ilgl, m_o_bjp, m_o_jal, m_o_jalr, m_o_bxx;
  logic m_o_rs1_en, m_o_rs2_en, m_o_prdt_taken;
  logic [31:0] m_o_instr;
  logic [4:0] m_o_rs1idx, m_o_rs2idx;
  logic [XLEN-1:0] m_o_pc, m_o_bjp_imm, m_o_prdt_pc;
  logic [CW-1:0] m_o_count;

  logic a_i_ready, a_o_valid, a_o_rv32, a_o_ilgl, a_o_bjp, a_o_jal, a_o_jalr, a_o_bxx;
  logic a_o_rs1_en, a_o_rs2_en, a_o_prdt_taken;
  logic [31:0] a_o_instr;
  logic [4:0] a_o_rs1idx, a_o_rs2idx;
  logic [XLEN-1:0] a_o_pc, a_o_bjp_imm, a_o_prdt_pc;
  logic [CW-1:0] a_o_count;

  always #5 clk = ~clk;

  ifu_predec_q #(.XLEN(XLEN), .DEPTH(DEPTH), .RVC_EN(1), .BTFN_EN(1)) u_main (
    .clk(clk), .rst_n(rst_n), .flush(flush), .i_valid(i_valid), .i_ready(m_i_ready),
    .i_instr(i_instr), .i_pc(i_pc), .o_valid(m_o_valid), .o_ready(o_ready),
    .o_instr(m_o_instr), .o_pc(m_o_pc), .o_rv32(m_o_rv32), .o_ilgl(m_o_ilgl),
    .o_bjp(m_o_bjp), .o_jal(m_o_jal), .o_jalr(m_o_jalr), .o_bxx(m_o_bxx),
    .o_rs1_en(m_o_rs1_en), .o_rs2_en(m_o_rs2_en), .o_rs1idx(m_o_rs1idx),
    .o_rs2idx(m_o_rs2idx), .o_bjp_imm(m_o_bjp_imm), .o_prdt_taken(m_o_prdt_taken),
    .o_prdt_pc(m_o_prdt_pc), .o_count(m_o_count));

  ifu_predec_q #(.XLEN(XLEN), .DEPTH(DEPTH), .RVC_EN(0), .BTFN_EN(0)) u_alt (
    .clk(clk), .rst_n(rst_n), .flush(flush), .i_valid(i_valid), .i_ready(a_i_ready),
    .i_instr(i_instr), .i_pc(i_pc), .o_valid(a_o_valid), .o_ready(o_ready),
    .o_instr(a_o_instr), .o_pc(a_o_pc), .o_rv32(a_o_rv32), .o_ilgl(a_o_ilgl),
    .o_bjp(a_o_bjp), .o_jal(a_o_jal), .o_jalr(a_o_jalr), .o_bxx(a_o_bxx),
    .o_rs1_en(a_o_rs1_en), .o_rs2_en(a_o_rs2_en), .o_rs1idx(a_o_rs1idx),
    .o_rs2idx(a_o_rs2idx), .o_bjp_imm(a_o_bjp_imm), .o_prdt_taken(a_o_prdt_taken),
    .o_prdt_pc(a_o_prdt_pc), .o_count(a_o_count));

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            rv32, jal, jalr, bxx, rs1_en, rs2_en, taken, a_ilgl, a_taken;
    logic [4:0]      rs1idx, rs2idx;
    logic [XLEN-1:0] imm, prdt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  logic last_push;

  function automatic exp_t mk(input logic [XLEN-1:0] pc, input logic [31:0] instr,
                              input logic rv32, jal, jalr, bxx,
                              input logic rs1_en, input logic [4:0] rs1idx,
                              input logic rs2_en, input logic [4:0] rs2idx,
                              input logic [XLEN-1:0] imm, input logic taken,
                              input logic [XLEN-1:0] prdt, input logic a_ilgl, a_taken);
    exp_t e;
    e.pc = pc; e.instr = instr; e.rv32 = rv32; e.jal = jal; e.jalr = jalr; e.bxx = bxx;
    e.rs1_en = rs1_en; e.rs1idx = rs1idx; e.rs2_en = rs2_en; e.rs2idx = rs2idx;
    e.imm = imm; e.taken = taken; e.prdt = prdt; e.a_ilgl = a_ilgl; e.a_taken = a_taken;
    return e;
  endfunction

  function automatic exp_t addi(input logic [XLEN-1:0] pc);
    return mk(pc, 32'h0000_0013, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_head(input exp_t e);
    logic bjp;
    bjp = e.jal | e.jalr | e.bxx;
    chk("valid", m_o_valid, 1);
    chk("pc", m_o_pc, e.pc);
    chk("instr", m_o_instr, e.instr);
    chk("rv32", m_o_rv32, e.rv32);
    chk("ilgl", m_o_ilgl, 0);
    chk("bjp", m_o_bjp, bjp);
    chk("jal", m_o_jal, e.jal);
    chk("jalr", m_o_jalr, e.jalr);
    chk("bxx", m_o_bxx, e.bxx);
    chk("bjp_imm", m_o_bjp_imm, e.imm);
    chk("prdt_taken", m_o_prdt_taken, e.taken);
    chk("prdt_pc", m_o_prdt_pc, e.prdt);
    if (bjp) begin
      chk("rs1_en", m_o_rs1_en, e.rs1_en);
      chk("rs2_en", m_o_rs2_en, e.rs2_en);
      if (e.rs1_en) chk("rs1idx", m_o_rs1idx, e.rs1idx);
      if (e.rs2_en) chk("rs2idx", m_o_rs2idx, e.rs2idx);
    end
    chk("alt_pc", a_o_pc, e.pc);
    chk("alt_ilgl", a_o_ilgl, e.a_ilgl);
    chk("alt_bjp", a_o_bjp, e.a_ilgl ? 1'b0 : bjp);
    chk("alt_taken", a_o_prdt_taken, e.a_taken);
  endtask

  // Decide this cycle's handshakes, update the scoreboard, advance one clock.
  task automatic cycle();
    exp_t e;
    last_push = 1'b0;
    if (!flush && o_ready && m_o_valid) begin
      if (sb.size() == 0) chk("deq_when_empty", m_o_valid, 0);
      else begin
        e = sb.pop_front();
        cmp_head(e);
      end
    end
    if (flush) sb.delete();
    else if (i_valid && m_i_ready) begin
      sb.push_back(cur);
      last_push = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input exp_t e);
    cur = e;
    i_valid = 1'b1;
    i_instr = e.instr;
    i_pc = e.pc;
  endtask

  task automatic drain();
    int n = 0;
    o_ready = 1'b1;
    while (sb.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    o_ready = 1'b0;
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d entries left expected 0", sb.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e_jal, e_beq, e_cnop;
    int n;
    e_jal  = mk(32'h8000_0000, 32'h0080_00EF, 1, 1, 0, 0, 0, 0, 0, 0,
                32'h8, 1, 32'h8000_0008, 0, 1);
    e_beq  = mk(32'h8000_0010, 32'hFE00_0EE3, 1, 0, 0, 1, 1, 0, 1, 0,
                32'hFFFF_FFFC, 1, 32'h8000_000C, 0, 0);
    e_cnop = mk(32'h8000_0020, 32'h0000_0001, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 1, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", m_o_valid, 0);
    chk("rst_count", m_o_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", m_o_valid, 0);
    chk("post_rst_ready", m_i_ready, 1);
    chk("post_rst_count", m_o_count, 0);

    // jal: one-cycle latency, no bypass
    drive(e_jal);
    chk("no_bypass", m_o_valid, 0);
    cycle();
    i_valid = 1'b0;
    chk("jal_count", m_o_count, 1);
    cmp_head(e_jal);

    drive(e_beq);
    cycle();
    i_valid = 1'b0;
    chk("cnt2", m_o_count, 2);

    // Simultaneous enqueue and dequeue at count 2
    drive(e_cnop);
    o_ready = 1'b1;
    cycle();
    i_valid = 1'b0;
    o_ready = 1'b0;
    chk("enq_deq_count", m_o_count, 2);
    drain();
    chk("empty_valid", m_o_valid, 0);
    chk("empty_count", a_o_count, 0);

    // Compressed jumps and branches
    drive(mk(32'h200, 32'h0000_8082, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0));
    cycle();
    drive(mk(32'h204, 32'h0000_A011, 0, 1, 0, 0, 0, 0, 0, 0, 32'h4, 1, 32'h208, 1, 0));
    cycle();
    drive(mk(32'h300, 32'h0000_DC7D, 0, 0, 0, 1, 1, 8, 0, 0,
             32'hFFFF_FFFE, 1, 32'h2FE, 1, 0));
    cycle();
    i_valid = 1'b0;
    drain();

    // Fill with o_ready low; fifth word must be held
    for (int k = 0; k < 5; k++) begin
      drive(addi(32'h1000 + 32'(4 * k)));
      cycle();
    end
    chk("full_ready", m_i_ready, 0);
    chk("full_count", m_o_count, 4);
    chk("alt_full_ready", a_i_ready, 0);
    cycle();
    chk("held_count", m_o_count, 4);
    o_ready = 1'b1;
    n = 0;
    while (!last_push && n < 8) begin
      cycle();
      n++;
    end
    chk("fifth_accepted", last_push, 1);
    i_valid = 1'b0;
    drain();

    // Flush at count 2 with a same-cycle enqueue
    drive(addi(32'h2000)); cycle();
    drive(addi(32'h2004)); cycle();
    chk("pre_flush_count", m_o_count, 2);
    drive(addi(32'h2008));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    i_valid = 1'b0;
    chk("flush_count", m_o_count, 0);
    chk("flush_valid", m_o_valid, 0);
    chk("alt_flush_count", a_o_count, 0);

    // Flush while full
    for (int k = 0; k < 4; k++) begin
      drive(addi(32'h3000 + 32'(4 * k)));
      cycle();
    end
    i_valid = 1'b0;
    flush = 1'b1;
    chk("flush_full_ready", m_i_ready, 0);
    cycle();
    flush = 1'b0;
    chk("after_flush_ready", m_i_ready, 1);
    chk("after_flush_count", m_o_count, 0);

    // Asynchronous reset mid-operation
    drive(addi(32'h4000)); cycle();
    i_valid = 1'b0;
    chk("pre_reset_count", m_o_count, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", m_o_count, 0);
    chk("async_rst_valid", m_o_valid, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_async_ready", m_i_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
